// File: rtl/mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// mips_multicycle_ctrl
//
// Multicycle control sequencer for a MIPS datapath with one shared ALU and a
// unified instruction/data memory. Each instruction walks through
// FETCH / DECODE / EXEC / MEM / WB steps; memory wait states are absorbed by
// holding FETCH, MEM_READ or MEM_WRITE until mem_ready is seen.
//
// Handshake: the memory side holds mem_read/mem_write asserted and the
// request completes on the first rising edge at which mem_ready is 1. The
// controller ignores mem_ready in every other state.
//
// Ports:
//   clk, rst          clock (rising edge) and asynchronous active-low reset
//   run               start/continue; sampled only at instruction boundaries
//   opcode            IR[31:26], stable from DECODE onward
//   mem_ready         memory completes the current access this cycle
//   pc_write ..       datapath control strobes/selects (combinational from
//   pc_source         state, opcode and mem_ready)
//   state             current state code (debug)
//   instr_done        last cycle of an instruction
//   illegal_op        unknown opcode seen in DECODE
//   instr_count       retired-instruction count, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module mips_multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             bne_sel,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_we,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic [3:0]       state,
    output logic             instr_done,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        MEM_ADDR  = 4'd3,
        MEM_READ  = 4'd4,
        MEM_WB    = 4'd5,
        MEM_WRITE = 4'd6,
        R_EXEC    = 4'd7,
        R_WB      = 4'd8,
        BRANCH    = 4'd9,
        JUMP      = 4'd10,
        ADDI_EXEC = 4'd11,
        ADDI_WB   = 4'd12
    } stateT;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    stateT curState;
    stateT nextState;
    stateT boundaryState;

    assign state = curState;

    // Where to go after the last cycle of an instruction (or an illegal
    // opcode): run is only looked at here.
    assign boundaryState = run ? FETCH : IDLE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            curState    <= IDLE;
            instr_count <= '0;
        end else begin
            curState <= nextState;
            if (instr_done) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        nextState     = IDLE;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        bne_sel       = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_we        = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 3'b000;
        pc_source     = 2'b00;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;

        case (curState)
            IDLE: begin
                nextState = run ? FETCH : IDLE;
            end

            FETCH: begin
                // PC + 1 is computed by the ALU every fetch cycle but only
                // committed together with the IR load once memory responds.
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                nextState = mem_ready ? DECODE : FETCH;
            end

            DECODE: begin
                // Branch target is speculatively computed into ALUOut.
                alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE:      nextState = R_EXEC;
                    OP_LW, OP_SW:  nextState = MEM_ADDR;
                    OP_BEQ, OP_BNE: nextState = BRANCH;
                    OP_J:          nextState = JUMP;
                    OP_ADDI:       nextState = ADDI_EXEC;
                    default: begin
                        // Unknown opcode is dropped without retiring.
                        illegal_op = 1'b1;
                        nextState  = boundaryState;
                    end
                endcase
            end

            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nextState = (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
            end

            MEM_READ: begin
                mem_read  = 1'b1;
                iord      = 1'b1;
                nextState = mem_ready ? MEM_WB : MEM_READ;
            end

            MEM_WB: begin
                reg_we     = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                nextState  = boundaryState;
            end

            MEM_WRITE: begin
                // The store retires in the cycle the memory accepts it.
                mem_write  = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ready;
                nextState  = mem_ready ? boundaryState : MEM_WRITE;
            end

            R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 3'b010;
                nextState = R_WB;
            end

            R_WB: begin
                reg_dst    = 1'b1;
                reg_we     = 1'b1;
                instr_done = 1'b1;
                nextState  = boundaryState;
            end

            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 3'b001;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                bne_sel       = (opcode == OP_BNE);
                instr_done    = 1'b1;
                nextState     = boundaryState;
            end

            JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                instr_done = 1'b1;
                nextState  = boundaryState;
            end

            ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nextState = ADDI_WB;
            end

            ADDI_WB: begin
                reg_we     = 1'b1;
                instr_done = 1'b1;
                nextState  = boundaryState;
            end

            // Unused codes 13-15 recover to IDLE with all outputs low.
            default: begin
                nextState = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mips_multicycle_ctrl
//
// Directed bench for the multicycle controller. A per-cycle vector table
// drives run/opcode/mem_ready and gives the hand-computed state, packed
// control word and retired count expected in that cycle. Hand-written
// sequences then cover asynchronous reset during a store, counter wrap with
// a 4-bit counter, and zero-wait cycle counts.
// ---------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             run;
    logic [5:0]       opcode;
    logic             mem_ready;
    logic             pc_write;
    logic             pc_write_cond;
    logic             bne_sel;
    logic             iord;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             mem_to_reg;
    logic             reg_dst;
    logic             reg_we;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [2:0]       alu_op;
    logic [1:0]       pc_source;
    logic [3:0]       state;
    logic             instr_done;
    logic             illegal_op;
    logic [CNT_W-1:0] instr_count;

    mips_multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .opcode       (opcode),
        .mem_ready    (mem_ready),
        .pc_write     (pc_write),
        .pc_write_cond(pc_write_cond),
        .bne_sel      (bne_sel),
        .iord         (iord),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .ir_write     (ir_write),
        .mem_to_reg   (mem_to_reg),
        .reg_dst      (reg_dst),
        .reg_we       (reg_we),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .pc_source    (pc_source),
        .state        (state),
        .instr_done   (instr_done),
        .illegal_op   (illegal_op),
        .instr_count  (instr_count)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed control word, bit 19 down to bit 0.
    logic [19:0] ctlAct;
    assign ctlAct = {pc_write, pc_write_cond, bne_sel, iord, mem_read, mem_write,
                     ir_write, mem_to_reg, reg_dst, reg_we, alu_src_a,
                     alu_src_b, alu_op, pc_source, instr_done, illegal_op};

    localparam logic [19:0] PW     = 20'd1 << 19;
    localparam logic [19:0] PWC    = 20'd1 << 18;
    localparam logic [19:0] BS     = 20'd1 << 17;
    localparam logic [19:0] IOD    = 20'd1 << 16;
    localparam logic [19:0] MR     = 20'd1 << 15;
    localparam logic [19:0] MW     = 20'd1 << 14;
    localparam logic [19:0] IRW    = 20'd1 << 13;
    localparam logic [19:0] M2R    = 20'd1 << 12;
    localparam logic [19:0] RD     = 20'd1 << 11;
    localparam logic [19:0] WE     = 20'd1 << 10;
    localparam logic [19:0] ASA    = 20'd1 << 9;
    localparam logic [19:0] ASB01  = 20'd1 << 7;
    localparam logic [19:0] ASB10  = 20'd2 << 7;
    localparam logic [19:0] ASB11  = 20'd3 << 7;
    localparam logic [19:0] AOP001 = 20'd1 << 4;
    localparam logic [19:0] AOP010 = 20'd2 << 4;
    localparam logic [19:0] PS01   = 20'd1 << 2;
    localparam logic [19:0] PS10   = 20'd2 << 2;
    localparam logic [19:0] DN     = 20'd1 << 1;
    localparam logic [19:0] IL     = 20'd1;

    // Expected control words per state (and mem_ready where it matters).
    localparam logic [19:0] C_IDLE    = 20'd0;
    localparam logic [19:0] C_FETCH_W = MR | ASB01;
    localparam logic [19:0] C_FETCH_R = MR | ASB01 | IRW | PW;
    localparam logic [19:0] C_DEC     = ASB11;
    localparam logic [19:0] C_DEC_ILL = ASB11 | IL;
    localparam logic [19:0] C_MADDR   = ASA | ASB10;
    localparam logic [19:0] C_MREAD   = MR | IOD;
    localparam logic [19:0] C_MWB     = WE | M2R | DN;
    localparam logic [19:0] C_MWR_W   = MW | IOD;
    localparam logic [19:0] C_MWR_R   = MW | IOD | DN;
    localparam logic [19:0] C_REXEC   = ASA | AOP010;
    localparam logic [19:0] C_RWB     = RD | WE | DN;
    localparam logic [19:0] C_BEQ     = ASA | AOP001 | PWC | PS01 | DN;
    localparam logic [19:0] C_BNE     = ASA | AOP001 | PWC | PS01 | DN | BS;
    localparam logic [19:0] C_JUMP    = PW | PS10 | DN;
    localparam logic [19:0] C_AEXEC   = ASA | ASB10;
    localparam logic [19:0] C_AWB     = WE | DN;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ILL  = 6'b111111;

    typedef struct {
        logic             run;
        logic [5:0]       op;
        logic             memReady;
        logic [3:0]       expState;
        logic [19:0]      expCtl;
        logic [CNT_W-1:0] expCount;
    } vecT;

    vecT vecs[$];

    int checks   = 0;
    int failures = 0;

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic addVec(input logic r, input logic [5:0] op, input logic mr,
                          input logic [3:0] st, input logic [19:0] ctl,
                          input logic [CNT_W-1:0] cnt);
        vecT v;
        v.run = r; v.op = op; v.memReady = mr;
        v.expState = st; v.expCtl = ctl; v.expCount = cnt;
        vecs.push_back(v);
    endtask

    // ---------------- driver ----------------
    // Runs one instruction starting from FETCH; returns cycles until the
    // instr_done cycle (inclusive), bounded so a stuck FSM cannot hang.
    task automatic runInstr(input logic [5:0] op, output int cycles);
        logic done;
        done   = 1'b0;
        cycles = 0;
        opcode = op;
        while (!done && cycles < 20) begin
            @(negedge clk);
            cycles++;
            if (instr_done) done = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            failures++;
            checks++;
            $display("FAIL runInstr_timeout: op=%b no instr_done in %0d cycles", op, cycles);
        end
    endtask

    initial begin
        int cyc;

        // ---- vector table: one entry per clock cycle ----
        // reset released, run=0 keeps IDLE; then run=1
        addVec(0, OP_R,    0, 0,  C_IDLE,    0);
        addVec(1, OP_R,    0, 0,  C_IDLE,    0);
        // R-type, zero wait: 1,2,7,8
        addVec(1, OP_R,    1, 1,  C_FETCH_R, 0);
        addVec(1, OP_R,    1, 2,  C_DEC,     0);
        addVec(1, OP_R,    1, 7,  C_REXEC,   0);
        addVec(1, OP_R,    1, 8,  C_RWB,     0);
        // lw: 2 fetch waits, 1 read wait: 1,1,1,2,3,4,4,5
        addVec(1, OP_LW,   0, 1,  C_FETCH_W, 1);
        addVec(1, OP_LW,   0, 1,  C_FETCH_W, 1);
        addVec(1, OP_LW,   1, 1,  C_FETCH_R, 1);
        addVec(1, OP_LW,   0, 2,  C_DEC,     1);
        addVec(1, OP_LW,   1, 3,  C_MADDR,   1);
        addVec(1, OP_LW,   0, 4,  C_MREAD,   1);
        addVec(1, OP_LW,   1, 4,  C_MREAD,   1);
        addVec(1, OP_LW,   0, 5,  C_MWB,     1);
        // beq then bne
        addVec(1, OP_BEQ,  1, 1,  C_FETCH_R, 2);
        addVec(1, OP_BEQ,  1, 2,  C_DEC,     2);
        addVec(1, OP_BEQ,  1, 9,  C_BEQ,     2);
        addVec(1, OP_BNE,  1, 1,  C_FETCH_R, 3);
        addVec(1, OP_BNE,  1, 2,  C_DEC,     3);
        addVec(1, OP_BNE,  1, 9,  C_BNE,     3);
        // sw with one write wait
        addVec(1, OP_SW,   1, 1,  C_FETCH_R, 4);
        addVec(1, OP_SW,   1, 2,  C_DEC,     4);
        addVec(1, OP_SW,   1, 3,  C_MADDR,   4);
        addVec(1, OP_SW,   0, 6,  C_MWR_W,   4);
        addVec(1, OP_SW,   1, 6,  C_MWR_R,   4);
        // addi
        addVec(1, OP_ADDI, 1, 1,  C_FETCH_R, 5);
        addVec(1, OP_ADDI, 1, 2,  C_DEC,     5);
        addVec(1, OP_ADDI, 1, 11, C_AEXEC,   5);
        addVec(1, OP_ADDI, 1, 12, C_AWB,     5);
        // illegal opcode with run=1: back to FETCH, no count
        addVec(1, OP_ILL,  1, 1,  C_FETCH_R, 6);
        addVec(1, OP_ILL,  1, 2,  C_DEC_ILL, 6);
        // j with run dropped mid-instruction: finishes, then IDLE
        addVec(1, OP_J,    1, 1,  C_FETCH_R, 6);
        addVec(0, OP_J,    1, 2,  C_DEC,     6);
        addVec(0, OP_J,    1, 10, C_JUMP,    6);
        addVec(0, OP_J,    1, 0,  C_IDLE,    7);
        // illegal opcode with run=0 at DECODE: goes to IDLE
        addVec(1, OP_ILL,  1, 0,  C_IDLE,    7);
        addVec(1, OP_ILL,  1, 1,  C_FETCH_R, 7);
        addVec(0, OP_ILL,  1, 2,  C_DEC_ILL, 7);
        addVec(0, OP_ILL,  1, 0,  C_IDLE,    7);

        // ---- reset ----
        rst       = 1'b0;
        run       = 1'b0;
        opcode    = OP_R;
        mem_ready = 1'b0;
        #2;
        check("reset_state", 32'(state), 32'd0);
        check("reset_ctl",   32'(ctlAct), 32'(C_IDLE));
        check("reset_count", 32'(instr_count), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // ---- table-driven section ----
        for (int i = 0; i < vecs.size(); i++) begin
            run       = vecs[i].run;
            opcode    = vecs[i].op;
            mem_ready = vecs[i].memReady;
            @(negedge clk);
            check($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].expState));
            check($sformatf("vec%0d_ctl", i),   32'(ctlAct), 32'(vecs[i].expCtl));
            check($sformatf("vec%0d_count", i), 32'(instr_count), 32'(vecs[i].expCount));
            @(posedge clk);
            #1;
        end

        // ---- asynchronous reset during a stalled store ----
        run       = 1'b1;
        opcode    = OP_SW;
        mem_ready = 1'b1;
        @(posedge clk); #1;   // IDLE -> FETCH
        @(posedge clk); #1;   // FETCH -> DECODE
        @(posedge clk); #1;   // DECODE -> MEM_ADDR
        mem_ready = 1'b0;
        @(posedge clk); #1;   // MEM_ADDR -> MEM_WRITE
        check("swrst_pre_state", 32'(state), 32'd6);
        check("swrst_pre_memwrite", 32'(mem_write), 32'd1);
        check("swrst_pre_count", 32'(instr_count), 32'd7);
        #2;
        rst = 1'b0;
        #1;
        check("swrst_state", 32'(state), 32'd0);
        check("swrst_memwrite", 32'(mem_write), 32'd0);
        check("swrst_ctl", 32'(ctlAct), 32'(C_IDLE));
        check("swrst_count", 32'(instr_count), 32'd0);

        // ---- counter wrap: 16 jumps with a 4-bit counter ----
        @(negedge clk);
        rst       = 1'b1;
        run       = 1'b1;
        mem_ready = 1'b1;
        @(posedge clk); #1;   // IDLE -> FETCH
        for (int n = 1; n <= 16; n++) begin
            runInstr(OP_J, cyc);
            check($sformatf("j%0d_cycles", n), 32'(cyc), 32'd3);
            if (n == 15) check("wrap_count15", 32'(instr_count), 32'd15);
            if (n == 16) check("wrap_count0", 32'(instr_count), 32'd0);
        end

        // ---- zero-wait cycle counts for other classes ----
        runInstr(OP_LW, cyc);
        check("lw_cycles", 32'(cyc), 32'd5);
        runInstr(OP_SW, cyc);
        check("sw_cycles", 32'(cyc), 32'd4);
        runInstr(OP_R, cyc);
        check("r_cycles", 32'(cyc), 32'd4);
        runInstr(OP_ADDI, cyc);
        check("addi_cycles", 32'(cyc), 32'd4);
        runInstr(OP_BNE, cyc);
        check("bne_cycles", 32'(cyc), 32'd3);
        check("final_count", 32'(instr_count), 32'd5);

        run = 1'b0;
        @(posedge clk); #1;

        // ---- report ----
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
